// File: rtl/memory_stage_if.sv
// Data-memory request/response channel used by memory_stage.
// master: the pipeline stage issuing loads/stores; slave: the data memory.
interface memory_stage_if;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata,
    output dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the five-stage pipeline. Holds the EX/MEM and
// MEM/WB registers and runs loads/stores over a valid/ready data-memory
// channel, stalling the front of the pipeline while an access is in flight.
// Optional feature: define DMEM_ALIGN_CHECK_EN to suppress requests for
// word-misaligned loads/stores and flag them on mem_misaligned.
module memory_stage (
  input  logic           clk,
  input  logic           rst,
  input  logic           ex_valid,
  input  logic [4:0]     ex_rd,
  input  logic [31:0]    ex_alu_res,
  input  logic [31:0]    ex_store_data,
  input  logic           ex_WriteBack,
  input  logic           ex_MemoryRead,
  input  logic           ex_MemoryWrite,
  output logic           mem_stall,
  output logic [4:0]     EXMEM_rd,
  output logic [31:0]    EXMEM_AluRES,
  output logic           EXMEM_WriteBack,
  output logic [4:0]     MEMWB_rd,
  output logic [31:0]    MEMWB_AluRES,
  output logic           MEMWB_WriteBack,
  memory_stage_if.master dmem,
  output logic           mem_misaligned
);
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e state_q, state_d;

  logic [REG_W-1:0]  rd_p0_q, rd_p0_d;
  logic [DATA_W-1:0] res_p0_q, res_p0_d;
  logic [DATA_W-1:0] sdata_p0_q, sdata_p0_d;
  logic              wb_p0_q, wb_p0_d;
  logic              mr_p0_q, mr_p0_d;
  logic              mw_p0_q, mw_p0_d;

  logic [REG_W-1:0]  rd_p1_q, rd_p1_d;
  logic [DATA_W-1:0] res_p1_q, res_p1_d;
  logic              wb_p1_q, wb_p1_d;

  logic done;
  logic ex_misal;
  logic p0_misal;
  logic ex_memop;
  logic p0_load;

`ifdef DMEM_ALIGN_CHECK_EN
  assign ex_misal = (ex_alu_res[1:0] != 2'b00);
  assign p0_misal = (mr_p0_q | mw_p0_q) & (res_p0_q[1:0] != 2'b00);
`else
  assign ex_misal = 1'b0;
  assign p0_misal = 1'b0;
`endif

  // A misaligned op (when checked) never reaches the memory, so it never starts an access.
  assign ex_memop = ex_valid & (ex_MemoryRead | ex_MemoryWrite) & ~ex_misal;
  assign p0_load  = mr_p0_q & ~mw_p0_q & ~p0_misal;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: a non-stalled edge either launches the next memory op or idles
  always_comb begin
    state_d = state_q;
    if (!mem_stall) begin
      state_d = ex_memop ? S_REQ : S_IDLE;
    end else if ((state_q == S_REQ) && dmem.dmem_req_ready) begin
      // only a load can be stalled in REQ while ready is high
      state_d = S_WAIT;
    end
  end

  // FSM outputs: request strobe, completion of the current access, and the stall
  always_comb begin
    done                = 1'b0;
    dmem.dmem_req_valid = 1'b0;
    case (state_q)
      S_REQ: begin
        dmem.dmem_req_valid = 1'b1;
        done                = dmem.dmem_req_ready & mw_p0_q;
      end
      S_WAIT:  done = dmem.dmem_rsp_valid;
      default: done = 1'b0;
    endcase
    mem_stall = (state_q != S_IDLE) & ~done;
  end

  // ---- EX -> EX/MEM (p0) ----
  // EX/MEM next value: capture EX when not stalled; an invalid EX slot becomes a bubble
  always_comb begin
    rd_p0_d    = rd_p0_q;
    res_p0_d   = res_p0_q;
    sdata_p0_d = sdata_p0_q;
    wb_p0_d    = wb_p0_q;
    mr_p0_d    = mr_p0_q;
    mw_p0_d    = mw_p0_q;
    if (!mem_stall) begin
      if (ex_valid) begin
        rd_p0_d    = ex_rd;
        res_p0_d   = ex_alu_res;
        sdata_p0_d = ex_store_data;
        wb_p0_d    = ex_WriteBack & (ex_rd != '0);
        mr_p0_d    = ex_MemoryRead;
        mw_p0_d    = ex_MemoryWrite;
      end else begin
        rd_p0_d    = '0;
        res_p0_d   = '0;
        sdata_p0_d = '0;
        wb_p0_d    = 1'b0;
        mr_p0_d    = 1'b0;
        mw_p0_d    = 1'b0;
      end
    end
  end

  // EX/MEM register
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_p0_q    <= '0;
      res_p0_q   <= '0;
      sdata_p0_q <= '0;
      wb_p0_q    <= 1'b0;
      mr_p0_q    <= 1'b0;
      mw_p0_q    <= 1'b0;
    end else begin
      rd_p0_q    <= rd_p0_d;
      res_p0_q   <= res_p0_d;
      sdata_p0_q <= sdata_p0_d;
      wb_p0_q    <= wb_p0_d;
      mr_p0_q    <= mr_p0_d;
      mw_p0_q    <= mw_p0_d;
    end
  end

  // ---- EX/MEM (p0) -> MEM/WB (p1) ----
  // MEM/WB next value: advance on a non-stalled edge (load data comes from memory), bubble otherwise
  always_comb begin
    rd_p1_d  = rd_p1_q;
    res_p1_d = res_p1_q;
    wb_p1_d  = 1'b0;
    if (!mem_stall) begin
      rd_p1_d  = rd_p0_q;
      wb_p1_d  = wb_p0_q & ~p0_misal;
      res_p1_d = p0_load ? dmem.dmem_rdata : res_p0_q;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_p1_q  <= '0;
      res_p1_q <= '0;
      wb_p1_q  <= 1'b0;
    end else begin
      rd_p1_q  <= rd_p1_d;
      res_p1_q <= res_p1_d;
      wb_p1_q  <= wb_p1_d;
    end
  end

  // Request fields come straight from EX/MEM, which is frozen while stalled.
  assign dmem.dmem_addr  = res_p0_q;
  assign dmem.dmem_wdata = sdata_p0_q;
  assign dmem.dmem_we    = mw_p0_q;

  assign mem_misaligned  = p0_misal;

  assign EXMEM_rd        = rd_p0_q;
  assign EXMEM_AluRES    = res_p0_q;
  assign EXMEM_WriteBack = wb_p0_q;
  assign MEMWB_rd        = rd_p1_q;
  assign MEMWB_AluRES    = res_p1_q;
  assign MEMWB_WriteBack = wb_p1_q;
endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios followed by random
// traffic, all checked against a transaction-level pipeline/memory model.
module tb_memory_stage;
  typedef struct packed {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] sd;
    logic        wb;
    logic        mr;
    logic        mw;
  } instr_t;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu_res;
  logic [31:0] ex_store_data;
  logic        ex_WriteBack, ex_MemoryRead, ex_MemoryWrite;
  logic        mem_stall;
  logic [4:0]  EXMEM_rd, MEMWB_rd;
  logic [31:0] EXMEM_AluRES, MEMWB_AluRES;
  logic        EXMEM_WriteBack, MEMWB_WriteBack;
  logic        mem_misaligned;

  memory_stage_if dmem_if ();

  memory_stage dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_rd           (ex_rd),
    .ex_alu_res      (ex_alu_res),
    .ex_store_data   (ex_store_data),
    .ex_WriteBack    (ex_WriteBack),
    .ex_MemoryRead   (ex_MemoryRead),
    .ex_MemoryWrite  (ex_MemoryWrite),
    .mem_stall       (mem_stall),
    .EXMEM_rd        (EXMEM_rd),
    .EXMEM_AluRES    (EXMEM_AluRES),
    .EXMEM_WriteBack (EXMEM_WriteBack),
    .MEMWB_rd        (MEMWB_rd),
    .MEMWB_AluRES    (MEMWB_AluRES),
    .MEMWB_WriteBack (MEMWB_WriteBack),
    .dmem            (dmem_if),
    .mem_misaligned  (mem_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  instr_t      prog_q[$];
  instr_t      cur_ex;
  instr_t      m_ex;
  logic        m_acc;
  logic [31:0] m_ldval;
  logic [4:0]  m_wrd;
  logic        m_wwb;
  logic [31:0] m_wval;
  logic [31:0] model_mem [256];
  logic [31:0] slave_mem [256];
  int          rsp_cnt;
  logic        rsp_stale;
  logic [7:0]  rsp_idx;
  logic        rsp_now;
  int          req_age, rdy_lat, rdy_min, rdy_max, rsp_min, rsp_max, spur_pct;
  logic        s_stall, s_acc, s_rst, s_reqv;
  logic        rst_req;
  int          n_vec, n_err, n_stall, n_req, n_mis;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_mis(input instr_t i);
    return ALIGN_EN && (i.mr || i.mw) && (i.alu[1:0] != 2'b00);
  endfunction

  function automatic logic live_op(input instr_t i);
    return (i.mr || i.mw) && !is_mis(i);
  endfunction

  // kind: 0 ALU, 1 load, 2 store
  function automatic instr_t mk(input logic [4:0] rd, input logic [31:0] a,
                                input logic [31:0] sd, input int kind);
    instr_t i;
    i     = '0;
    i.v   = 1'b1;
    i.rd  = rd;
    i.alu = a;
    i.sd  = sd;
    i.mr  = (kind == 1);
    i.mw  = (kind == 2);
    i.wb  = (kind != 2);
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int     k;
    logic [31:0] a;
    k = int'($urandom_range(3));
    a = {22'd0, 10'($urandom_range(1023))};
    if (k >= 2 && $urandom_range(9) != 0) a[1:0] = 2'b00;
    i = mk(5'($urandom_range(31)), (k >= 2) ? a : $urandom, $urandom, (k >= 2) ? k - 1 : 0);
    if (k < 2) i.wb = ($urandom_range(4) != 0);
    if ($urandom_range(7) == 0) i.v = 1'b0;
    return i;
  endfunction

  // One clock: apply the edge to the model, drive the next inputs, then compare.
  task automatic cycle();
    instr_t n;
    logic   exp_reqv, done, exp_stall, mis;
    @(posedge clk);
    #1;
    if (s_rst) begin
      m_ex = '0; m_acc = 1'b0; m_wrd = '0; m_wwb = 1'b0; m_wval = '0;
      cur_ex = '0; rsp_stale = 1'b1; req_age = 0;
    end else begin
      if (s_acc) begin
        if (m_ex.mw) slave_mem[m_ex.alu[9:2]] = m_ex.sd;
        else begin
          rsp_cnt   = int'($urandom_range(rsp_max, rsp_min));
          rsp_stale = 1'b0;
          rsp_idx   = m_ex.alu[9:2];
        end
        m_acc   = 1'b1;
        req_age = 0;
        rdy_lat = int'($urandom_range(rdy_max, rdy_min));
      end else if (s_reqv) begin
        req_age++;
      end
      if (!s_stall) begin
        m_wrd  = m_ex.rd;
        m_wwb  = m_ex.wb && !is_mis(m_ex);
        m_wval = (m_ex.mr && !m_ex.mw && !is_mis(m_ex)) ? m_ldval : m_ex.alu;
        n = cur_ex;
        if (!n.v) n = '0;
        if (n.rd == 5'd0) n.wb = 1'b0;
        m_ex  = n;
        m_acc = 1'b0;
        if (live_op(n)) begin
          if (n.mw) model_mem[n.alu[9:2]] = n.sd;
          else      m_ldval = model_mem[n.alu[9:2]];
        end
        cur_ex = (prog_q.size() > 0) ? prog_q.pop_front() : '0;
      end else begin
        m_wwb = 1'b0;
      end
    end
    // drive memory side
    rsp_now = 1'b0;
    dmem_if.dmem_rsp_valid = 1'b0;
    dmem_if.dmem_rdata     = $urandom;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        dmem_if.dmem_rsp_valid = 1'b1;
        dmem_if.dmem_rdata     = slave_mem[rsp_idx];
        rsp_now = !rsp_stale;
        rsp_cnt = -1;
      end
    end else if (int'($urandom_range(99)) < spur_pct) begin
      dmem_if.dmem_rsp_valid = 1'b1;
    end
    exp_reqv = live_op(m_ex) && !m_acc;
    dmem_if.dmem_req_ready = exp_reqv ? (req_age >= rdy_lat) : ($urandom_range(1) == 1);
    // drive EX side
    rst            = rst_req;
    ex_valid       = cur_ex.v;
    ex_rd          = cur_ex.rd;
    ex_alu_res     = cur_ex.alu;
    ex_store_data  = cur_ex.sd;
    ex_WriteBack   = cur_ex.wb;
    ex_MemoryRead  = cur_ex.mr;
    ex_MemoryWrite = cur_ex.mw;
    #1;
    mis       = is_mis(m_ex);
    done      = live_op(m_ex) && (m_acc ? rsp_now : (dmem_if.dmem_req_ready && m_ex.mw));
    exp_stall = live_op(m_ex) && !done;
    chk("stall", 32'(mem_stall), 32'(exp_stall));
    chk("req_valid", 32'(dmem_if.dmem_req_valid), 32'(exp_reqv));
    chk("misaligned", 32'(mem_misaligned), 32'(mis));
    chk("exmem_wb", 32'(EXMEM_WriteBack), 32'(m_ex.wb));
    if (m_ex.v) begin
      chk("exmem_rd", 32'(EXMEM_rd), 32'(m_ex.rd));
      chk("exmem_res", EXMEM_AluRES, m_ex.alu);
    end
    chk("memwb_wb", 32'(MEMWB_WriteBack), 32'(m_wwb));
    if (m_wwb) begin
      chk("memwb_rd", 32'(MEMWB_rd), 32'(m_wrd));
      chk("memwb_res", MEMWB_AluRES, m_wval);
    end
    if (exp_reqv) begin
      chk("req_addr", dmem_if.dmem_addr, m_ex.alu);
      chk("req_we", 32'(dmem_if.dmem_we), 32'(m_ex.mw));
      if (m_ex.mw) chk("req_wdata", dmem_if.dmem_wdata, m_ex.sd);
    end
    if (mem_stall) n_stall++;
    if (dmem_if.dmem_req_valid) n_req++;
    if (mem_misaligned) n_mis++;
    s_rst   = rst;
    s_reqv  = exp_reqv;
    s_acc   = exp_reqv && dmem_if.dmem_req_ready;
    s_stall = exp_stall;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clr_counts();
    n_stall = 0; n_req = 0; n_mis = 0;
  endtask

  task automatic set_lat(input int rdy, input int rsp);
    rdy_min = rdy; rdy_max = rdy; rdy_lat = rdy;
    rsp_min = rsp; rsp_max = rsp;
  endtask

  initial begin
    int k;
    n_vec = 0; n_err = 0;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = '0;
      slave_mem[i] = '0;
    end
    cur_ex = '0; m_ex = '0; m_acc = 1'b0; m_ldval = '0;
    m_wrd = '0; m_wwb = 1'b0; m_wval = '0;
    rsp_cnt = -1; rsp_stale = 1'b1; rsp_idx = '0; rsp_now = 1'b0;
    req_age = 0; spur_pct = 0;
    set_lat(0, 1);
    rst = 1'b1; rst_req = 1'b1;
    s_rst = 1'b1; s_reqv = 1'b0; s_acc = 1'b0; s_stall = 1'b0;
    ex_valid = 1'b0; ex_rd = '0; ex_alu_res = '0; ex_store_data = '0;
    ex_WriteBack = 1'b0; ex_MemoryRead = 1'b0; ex_MemoryWrite = 1'b0;
    dmem_if.dmem_req_ready = 1'b0;
    dmem_if.dmem_rsp_valid = 1'b0;
    dmem_if.dmem_rdata     = '0;
    clr_counts();

    // reset held two cycles: every output at its reset value
    run(2);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_req_valid", 32'(dmem_if.dmem_req_valid), 32'd0);
    chk("rst_we", 32'(dmem_if.dmem_we), 32'd0);
    chk("rst_addr", dmem_if.dmem_addr, 32'd0);
    chk("rst_wdata", dmem_if.dmem_wdata, 32'd0);
    chk("rst_misaligned", 32'(mem_misaligned), 32'd0);
    chk("rst_exmem_rd", 32'(EXMEM_rd), 32'd0);
    chk("rst_exmem_res", EXMEM_AluRES, 32'd0);
    chk("rst_exmem_wb", 32'(EXMEM_WriteBack), 32'd0);
    chk("rst_memwb_rd", 32'(MEMWB_rd), 32'd0);
    chk("rst_memwb_res", MEMWB_AluRES, 32'd0);
    chk("rst_memwb_wb", 32'(MEMWB_WriteBack), 32'd0);
    rst_req = 1'b0;
    run(2);

    // ALU op to x5, then the same op to x0
    clr_counts();
    prog_q.push_back(mk(5'd5, 32'h0000_1234, 32'h0, 0));
    prog_q.push_back(mk(5'd0, 32'h0000_1234, 32'h0, 0));
    run(6);
    chk("alu_stall_cycles", 32'(n_stall), 32'd0);

    // store with ready low for three cycles
    set_lat(3, 1);
    clr_counts();
    prog_q.push_back(mk(5'd6, 32'h0000_0100, 32'hDEAD_BEEF, 2));
    run(8);
    chk("store_stall_cycles", 32'(n_stall), 32'd3);
    chk("store_req_cycles", 32'(n_req), 32'd4);

    // load: accepted at once, two idle WAIT cycles, then the response
    set_lat(0, 3);
    model_mem[8'h80] = 32'hCAFE_0001;
    slave_mem[8'h80] = 32'hCAFE_0001;
    clr_counts();
    prog_q.push_back(mk(5'd7, 32'h0000_0200, 32'h0, 1));
    run(8);
    chk("load_stall_cycles", 32'(n_stall), 32'd3);

    // back-to-back load then store, zero wait
    set_lat(0, 1);
    clr_counts();
    prog_q.push_back(mk(5'd8, 32'h0000_0200, 32'h0, 1));
    prog_q.push_back(mk(5'd9, 32'h0000_0204, 32'h1357_9BDF, 2));
    k = 0;
    do begin
      cycle();
      k++;
    end while (!rsp_now && k < 20);
    chk("b2b_rsp_seen", 32'(rsp_now), 32'd1);
    cycle();
    chk("b2b_store_req", 32'(dmem_if.dmem_req_valid), 32'd1);
    chk("b2b_store_we", 32'(dmem_if.dmem_we), 32'd1);
    run(4);
    chk("b2b_stall_cycles", 32'(n_stall), 32'd1);

    // load from a misaligned address
    clr_counts();
    prog_q.push_back(mk(5'd10, 32'h0000_0202, 32'h0, 1));
    run(6);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("misal_req_cycles", 32'(n_req), 32'd0);
    chk("misal_pulse_cycles", 32'(n_mis), 32'd1);
    chk("misal_stall_cycles", 32'(n_stall), 32'd0);
`else
    chk("misal_req_cycles", 32'(n_req), 32'd1);
    chk("misal_pulse_cycles", 32'(n_mis), 32'd0);
    chk("misal_stall_cycles", 32'(n_stall), 32'd1);
`endif

    // reset held two cycles while a load waits; its late response must be ignored
    set_lat(0, 4);
    prog_q.push_back(mk(5'd11, 32'h0000_0300, 32'h0, 1));
    k = 0;
    do begin
      cycle();
      k++;
    end while (!m_acc && k < 20);
    chk("rstmid_load_accepted", 32'(m_acc), 32'd1);
    rst_req = 1'b1;
    run(2);
    chk("rstmid_req_valid", 32'(dmem_if.dmem_req_valid), 32'd0);
    chk("rstmid_stall", 32'(mem_stall), 32'd0);
    rst_req = 1'b0;
    clr_counts();
    run(5);
    chk("rstmid_stall_cycles", 32'(n_stall), 32'd0);

    // random traffic with random latencies, stray responses and occasional reset
    rdy_min = 0; rdy_max = 3; rsp_min = 1; rsp_max = 3; spur_pct = 10;
    for (int i = 0; i < 3000; i++) begin
      if (prog_q.size() < 2) prog_q.push_back(rand_instr());
      rst_req = ($urandom_range(299) == 0);
      cycle();
    end
    rst_req = 1'b0;
    spur_pct = 0;
    run(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
